// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and counter sizing for the multiply/divide unit
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  function automatic int cnt_width(int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration; divide step only when MULDIV_DIV_EN is defined
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  assign w_sum    = {1'b0, i_hi} + {1'b0, (i_lo[0] ? i_opnd : {WIDTH{1'b0}})};
  assign w_mul_hi = w_sum[WIDTH:1];
  assign w_mul_lo = {w_sum[0], i_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_diff;
  logic           w_ok;
  assign w_sh   = {i_hi, i_lo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, i_opnd};
  assign w_ok   = ~w_diff[WIDTH];
  assign o_hi   = i_mode ? (w_ok ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0]) : w_mul_hi;
  assign o_lo   = i_mode ? {i_lo[WIDTH-2:0], w_ok} : w_mul_lo;
`else
  assign o_hi   = i_mode ? i_hi : w_mul_hi;
  assign o_lo   = i_mode ? i_lo : w_mul_lo;
`endif
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO; DIV/DIVU built only with MULDIV_DIV_EN
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = cnt_width(WIDTH);
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_done;
  logic               w_div;
  logic               w_go;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_nxt_hi;
  logic [WIDTH-1:0]   w_nxt_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_n;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;
`ifdef MULDIV_DIV_EN
  assign w_div = op[1];
`else
  assign w_div = 1'b0;
`endif
  assign w_go     = start && r_state == IDLE && (w_div || !op[1]);
  assign w_sa     = (op == OP_MULT || op == OP_DIV) && a[WIDTH-1];
  assign w_sb     = (op == OP_MULT || op == OP_DIV) && b[WIDTH-1];
  assign w_abs_a  = w_sa ? -a : a;
  assign w_abs_b  = w_sb ? -b : b;
  assign w_prod   = {r_acc_hi, r_acc_lo};
  assign w_prod_n = r_neg_q ? -w_prod : w_prod;
  assign w_fix_hi = r_is_div ? (r_neg_r ? -r_acc_hi : r_acc_hi) : w_prod_n[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? (r_neg_q ? -r_acc_lo : r_acc_lo) : w_prod_n[WIDTH-1:0];
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_mode(r_is_div),
    .i_hi  (r_acc_hi),
    .i_lo  (r_acc_lo),
    .i_opnd(r_opnd),
    .o_hi  (w_nxt_hi),
    .o_lo  (w_nxt_lo)
  );
  // control FSM: latch magnitudes, iterate one step per cycle, sign-fix into HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (w_go) begin
            r_is_div <= w_div;
            r_acc_hi <= '0;
            r_acc_lo <= w_div ? w_abs_a : w_abs_b;
            r_opnd   <= w_div ? w_abs_b : w_abs_a;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_cnt    <= CW'(WIDTH - 1);
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_acc_hi <= w_nxt_hi;
          r_acc_lo <= w_nxt_lo;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= FIX;
        end
        FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32); divide cases follow MULDIV_DIV_EN
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

`ifdef MULDIV_DIV_EN
  localparam int MAXOP = 3;
`else
  localparam int MAXOP = 1;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      px;
    longint      py;
    int          sx;
    int          sy;
    logic [31:0] qq;
    logic [31:0] rr;
    px = longint'($signed(x));
    py = longint'($signed(y));
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'b00: return 64'(px * py);
      2'b01: return {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) return {x, (x[31] ? 32'd1 : 32'hFFFF_FFFF)};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        qq = 32'(sx / sy);
        rr = 32'(sx % sy);
        return {rr, qq};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // drive one start for a cycle; optionally expect a result WIDTH+2 cycles later
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    exp_t        e;
    logic [63:0] r;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (push) begin
      r = model(o, x, y);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.cyc = cyc + 34;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      check("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check("busy_at_done", 64'(busy), 64'd0);
      if (q.size() == 0) check("spurious_done", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int k = 1; k <= 33; k++) begin
      check("busy_window", 64'(busy), 64'd1);
      @(negedge clk);
    end
    check("busy_low_at_done", 64'(busy), 64'd0);
    issue(2'b00, -32'sd3, 32'd5, 1'b1);
    drain();

    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", 64'(hi), 64'h1234);
    lo_we = 1'b1;
    wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", 64'(lo), 64'h5678);

    lo_we = 1'b1;
    wdata = 32'h99;
    issue(2'b01, 32'd6, 32'd7, 1'b1);
    lo_we = 1'b0;
    check("mtlo_with_start", 64'(lo), 64'h99);
    drain();

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(2'($urandom_range(0, MAXOP)), $urandom, (i == 3) ? 32'd0 : $urandom, 1'b1);
      drain();
    end

`ifdef MULDIV_DIV_EN
    @(negedge clk);
    issue(2'b10, -32'sd7, 32'd2, 1'b1);
    drain();
    issue(2'b11, 32'd7, 32'd0, 1'b1);
    drain();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    drain();
    issue(2'b10, -32'sd100, 32'd0, 1'b1);
    drain();
`else
    @(negedge clk);
    issue(2'b10, -32'sd7, 32'd2, 1'b0);
    check("div_off_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("div_off_hi", 64'(hi), 64'(last_hi));
    check("div_off_lo", 64'(lo), 64'(last_lo));
`endif

    @(negedge clk);
    issue(2'b01, 32'd6, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op = 2'b11;
    a = 32'd100;
    b = 32'd3;
    hi_we = 1'b1;
    wdata = 32'h55;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    drain();

    @(negedge clk);
    issue(2'b00, -32'sd3, 32'd5, 1'b1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    q.delete();
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
